// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM burst controller slice.
package sram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO that absorbs SRAM read data while the consumer stalls.
module sram_rd_skid
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointer and occupancy tracking; push and pop may coincide even when full.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage; when full, a simultaneous push overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst initiator for a single-port 256x32 SRAM with registered read data.
module sram_burst_ctrl
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W:0]   issue_left;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              cmd_fire;
  logic              pop;
  logic              issue;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign mem_we    = (state == WRITE) && wr_valid;
  assign mem_addr  = addr;
  assign mem_wdata = wr_data;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rd_valid  = (fifo_count != 2'd0);
  assign pop       = rd_valid && rd_ready;

  // Buffered + in-flight + the new issue must fit in two slots after this edge's pop;
  // rearranged as count + inflight + 1 <= 2 + pop to stay unsigned.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} + 3'd1;
  assign issue     = (state == READ) && (issue_left != '0) &&
                     (occupancy <= (3'd2 + {2'b00, pop}));

  // Burst FSM: command capture, address/count stepping, done pulse and inflight flag.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      issue_left <= '0;
      inflight   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            addr       <= cmd_addr;
            remaining  <= cmd_len;
            issue_left <= {1'b0, cmd_len} + (ADDR_W+1)'(1);
            state      <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (mem_we) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr       <= addr + ADDR_W'(1);
            issue_left <= issue_left - (ADDR_W+1)'(1);
          end
          if (pop) begin
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sram_rd_skid u_skid (
    .clk       (clk),
    .res       (res),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (rd_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed scoreboard bench for sram_burst_ctrl with a behavioural registered-read SRAM.
module tb_sram_burst_ctrl;
  import sram_pkg::*;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] sram   [256];
  logic [DATA_W-1:0] shadow [256];
  logic [DATA_W-1:0] sbq    [$];

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  sram_burst_ctrl dut (
    .clk       (clk),
    .res       (res),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, registered read of the presented address.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Called at a falling edge with the DUT idle; returns 1 time unit into cycle 1.
  task automatic start_cmd(input logic w, input logic [7:0] a, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = len;
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 check("busy_after_cmd", 32'(busy), 32'd1);
  endtask

  task automatic write_burst(input logic [7:0] a, input logic [7:0] len,
                             input logic [31:0] base, input bit stall);
    int i = 0;
    int guard = 0;
    bit stalled = 1'b0;
    int d0 = done_cnt;
    logic [7:0] wa;
    start_cmd(1'b1, a, len);
    while (i <= int'(len) && guard < 600) begin
      guard++;
      if (stall && i == 1 && !stalled) begin
        wr_valid = 1'b0;
        stalled  = 1'b1;
        #1 check("wr_stall_we", 32'(mem_we), 32'd0);
      end else begin
        wa = a + 8'(i);
        wr_valid = 1'b1;
        wr_data  = base + 32'(i);
        #1;
        check("wr_ready", 32'(wr_ready), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'(wa));
        check("wr_wdata", mem_wdata, base + 32'(i));
        check("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        shadow[wa] = base + 32'(i);
        i++;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    check("wr_beats", 32'(i), 32'(int'(len) + 1));
    check("wr_done", 32'(done), 32'd1);
    check("wr_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("wr_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("wr_done_pulse_end", 32'(done), 32'd0);
    check("wr_done_count", 32'(done_cnt - d0), 32'd1);
    for (int j = 0; j <= int'(len); j++) begin
      wa = a + 8'(j);
      check("wr_sram_word", sram[wa], shadow[wa]);
    end
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [7:0] len,
                            input int mode, input bit timing);
    int n = int'(len) + 1;
    int got = 0;
    int cyc = 1;
    int first = -1;
    int last = -1;
    int d0 = done_cnt;
    logic [31:0] prev = '0;
    logic [31:0] exp;
    logic [7:0] ra;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    for (int i = 0; i < n; i++) begin
      ra = a + 8'(i);
      sbq.push_back(shadow[ra]);
    end
    start_cmd(1'b0, a, len);
    while (!fin && cyc < 4 * n + 20) begin
      if (got == n) begin
        check("rd_done", 32'(done), 32'd1);
        check("rd_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("rd_valid_after", 32'(rd_valid), 32'd0);
        fin = 1'b1;
      end else begin
        check("rd_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("rd_no_early_done", 32'(done), 32'd0);
        check("rd_we_low", 32'(mem_we), 32'd0);
        if (stalled) begin
          check("rd_valid_held", 32'(rd_valid), 32'd1);
          check("rd_stable", rd_data, prev);
        end
        if (rd_valid && first < 0) first = cyc;
        rd_ready = ready_pat(mode, cyc);
        if (rd_valid && rd_ready) begin
          exp = sbq.pop_front();
          check("rd_data", rd_data, exp);
          got++;
          last = cyc;
        end
        stalled = rd_valid && !rd_ready;
        prev    = rd_data;
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    rd_ready = 1'b0;
    check("rd_beats", 32'(got), 32'(n));
    check("rd_queue_empty", 32'(sbq.size()), 32'd0);
    if (timing) begin
      check("rd_first_latency", 32'(first), 32'd3);
      check("rd_back_to_back", 32'(last - first), 32'(n - 1));
    end
    @(negedge clk);
    #1 check("rd_done_count", 32'(done_cnt - d0), 32'd1);
    sbq.delete();
  endtask

  initial begin
    int pops;
    int guard;
    int d0;

    // Reset state
    #1 res = 1'b1;
    @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // Basic write then full-rate readback with latency check
    write_burst(8'h10, 8'd3, 32'h0000_00A0, 1'b0);
    read_burst(8'h10, 8'd3, 0, 1'b1);

    // Write with a wr_valid stall, then 1-0-0-1 read backpressure
    write_burst(8'h40, 8'd7, 32'h1000_0000, 1'b1);
    read_burst(8'h40, 8'd7, 1, 1'b0);

    // Address wrap through 0xFF -> 0x00, random backpressure readback
    write_burst(8'hFE, 8'd3, 32'h5500_00F0, 1'b0);
    read_burst(8'hFE, 8'd3, 2, 1'b0);

    // Reset in the middle of a read after two delivered beats
    d0 = done_cnt;
    pops = 0;
    guard = 0;
    start_cmd(1'b0, 8'h40, 8'd7);
    rd_ready = 1'b1;
    while (pops < 2 && guard < 20) begin
      if (rd_valid) begin
        check("abort_rd_data", rd_data, shadow[8'h40 + 8'(pops)]);
        pops++;
      end
      @(negedge clk);
      #1;
      guard++;
    end
    check("abort_pops", 32'(pops), 32'd2);
    res = 1'b1;
    #1;
    check("abort_rd_valid", 32'(rd_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    res = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    #1 check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);

    // Single-beat transfers after the abort
    write_burst(8'h80, 8'd0, 32'hDEAD_BEEF, 1'b0);
    read_burst(8'h80, 8'd0, 0, 1'b1);

    // Maximum burst length
    write_burst(8'h00, 8'd255, 32'hC0DE_0000, 1'b0);
    read_burst(8'h00, 8'd255, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst initiator for the single-port 256x32 SRAM: accepts one command (read or write, start address, beat count), drives the SRAM's write-enable/address/data pins and moves data between the SRAM and valid/ready streams. Reads are decoupled from the SRAM's one-cycle registered read latency by a 2-entry skid buffer. This gives full throughput under consumer backpressure. Sits between the CPU/DMA fabric and the SRAM instance.

## Interface
- ADDR_W, 8, SRAM address width (256 words)
- DATA_W, 32, SRAM word width
- clk  in  1  single clock; all state changes on rising edge
- res  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  beats minus one (0 → 1 beat, 255 → 256 beats)
- wr_valid / wr_ready / wr_data  in / out / in  1/1/DATA_W  write stream
- rd_valid / rd_ready / rd_data  out / in / out  1/1/DATA_W  read stream
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final beat
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM registered read data (valid the cycle after a non-write cycle)

## Operation
- States: IDLE, WRITE, READ. Command handshake (cmd_valid && cmd_ready) latches addr and remaining = cmd_len. Next state is WRITE or READ according to cmd_write.
- WRITE: wr_ready = 1. mem_we = wr_valid, mem_wdata = wr_data, mem_addr = addr register (combinational).
  - Each accepted beat: addr+1, remaining-1.
  - Beat with remaining == 0 → IDLE, done = 1 next cycle.
  - wr_valid low stalls with mem_we = 0.
- READ: mem_we = 0. A read issue occurs in a cycle when beats_left_to_issue > 0 and fifo_count + inflight − pop + 1 ≤ 2, where pop = rd_valid && rd_ready.
  - An issue advances addr.
  - inflight register = issued last cycle. When inflight = 1, mem_rdata is pushed into the skid FIFO at the edge.
  - rd_valid = FIFO non-empty; rd_data = FIFO head.
  - After the final rd handshake → IDLE, done = 1 next cycle.
- Outside WRITE, mem_we = 0. mem_addr holds the addr register. mem_wdata = wr_data.
- Address arithmetic is modulo 2^ADDR_W: 255 + 1 wraps to 0 within a burst.
- Commands offered while busy stall (cmd_ready = 0). No queuing.
- Push and pop in the same cycle on a full FIFO is legal; the issue rule guarantees no overflow.

## Timing
- Reset (async, any time, including mid-burst):
  - state = IDLE; FIFO empty; inflight = 0; addr = 0; remaining = 0.
  - Outputs: rd_valid = 0, done = 0, busy = 0, mem_we = 0, mem_addr = 0, cmd_ready = 1, wr_ready = 0.
  - Aborted burst produces no done pulse.
- Write: beat accepted in cycle N writes SRAM at edge N. Max 1 beat/cycle. Last beat in cycle N → done high in cycle N+1, cmd_ready high in N+1.
- Read: command accepted at edge 0.
  - First issue in cycle 1.
  - Data in mem_rdata in cycle 2, pushed at edge 2.
  - rd_valid first high in cycle 3 (latency 3 from handshake).
  - With rd_ready held high: one beat per cycle, zero bubbles.
- Backpressure: rd_ready low for any duration loses no data. At most 2 words buffered plus 0 in flight when stalled.
- rd_data is stable while rd_valid && !rd_ready.

## Structure
- Shared package sram_pkg: ADDR_W, DATA_W, state encoding (IDLE = 0, WRITE = 1, READ = 2).
- Sub-module sram_rd_skid: 2-entry FIFO with push/pop/count, head output, same clk/res.
- Top holds the FSM, address/count registers, the issue rule and the inflight flag.

## Test plan
- Write burst: addr 0x10, len 3, data 0xA0..0xA3 with wr_valid continuous → SRAM words 0x10..0x13 = 0xA0..0xA3, done one cycle after 4th beat.
- Read burst: same region, rd_ready always 1 → rd_data 0xA0..0xA3 on four consecutive cycles, first rd_valid 3 cycles after command.
- Read backpressure: len 7, rd_ready toggled 1-0-0-1 pattern → exact in-order data, no drops/duplicates, rd_data stable during stall.
- Wrap: write addr 0xFE, len 3 → words 0xFE, 0xFF, 0x00, 0x01 written; readback matches.
- Reset mid-burst: assert res during a read after 2 beats → rd_valid, busy, mem_we drop immediately, no done; new 1-beat command after release completes normally.
- Max burst: len 255 from addr 0 → 256 beats, done exactly once, cmd_ready low throughout.
